// File: rtl/dds_phase_addr_gen.sv
// Phase-accumulator ROM address generator with wrap-deferred (phase-continuous) retuning.
// Optional LFSR truncation dither is compiled in when DDS_PHASE_DITHER_EN is defined.
module dds_phase_addr_gen #(
    parameter int PHASE_WIDTH = 32,
    parameter int ADDR_WIDTH  = 10
) (
    input  logic                   clk_tb,
    input  logic                   tb_rst,
    input  logic                   en,
    input  logic                   cfg_valid,
    output logic                   cfg_ready,
    input  logic [PHASE_WIDTH-1:0] cfg_fword,
    input  logic [PHASE_WIDTH-1:0] cfg_poff,
    output logic [ADDR_WIDTH-1:0]  addr_o,
    output logic                   addr_valid,
    output logic                   wrap_o
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        PEND = 2'd2
    } state_t;

    state_t                 state_reg, state_next;
    logic [PHASE_WIDTH-1:0] acc_reg, acc_next;
    logic [PHASE_WIDTH-1:0] fword_reg, fword_next;
    logic [PHASE_WIDTH-1:0] poff_reg, poff_next;
    logic [PHASE_WIDTH-1:0] sh_fword_reg, sh_fword_next;
    logic [PHASE_WIDTH-1:0] sh_poff_reg, sh_poff_next;
    logic                   live_reg;
    logic                   carry_reg, carry_next;
    logic                   wrap_next;
    logic                   addr_valid_next;
    logic [ADDR_WIDTH-1:0]  addr_next;

    logic [PHASE_WIDTH:0]   inc_full;
    logic [PHASE_WIDTH-1:0] acc_sum;
    logic                   carry;
    logic [PHASE_WIDTH-1:0] phase_sum;
    logic                   cfg_take;

    assign inc_full  = {1'b0, acc_reg} + {1'b0, fword_reg};
    assign acc_sum   = inc_full[PHASE_WIDTH-1:0];
    assign carry     = inc_full[PHASE_WIDTH];
    // live_reg keeps cfg_ready low until the first edge after reset release
    assign cfg_ready = live_reg & (state_reg != PEND);
    assign cfg_take  = cfg_valid & cfg_ready;

`ifdef DDS_PHASE_DITHER_EN
    localparam int DITHER_W = (PHASE_WIDTH - ADDR_WIDTH < 16) ? (PHASE_WIDTH - ADDR_WIDTH) : 16;

    logic [15:0] lfsr_reg, lfsr_next;

    assign lfsr_next = {lfsr_reg[14:0], lfsr_reg[15] ^ lfsr_reg[13] ^ lfsr_reg[12] ^ lfsr_reg[10]};
    assign phase_sum = acc_reg + poff_reg + PHASE_WIDTH'(lfsr_reg[DITHER_W-1:0]);

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            lfsr_reg <= 16'hACE1;
        end else if (state_reg != IDLE) begin
            lfsr_reg <= lfsr_next;
        end
    end
`else
    assign phase_sum = acc_reg + poff_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        acc_next      = acc_reg;
        fword_next    = fword_reg;
        poff_next     = poff_reg;
        sh_fword_next = sh_fword_reg;
        sh_poff_next  = sh_poff_reg;
        carry_next    = 1'b0;

        case (state_reg)
            IDLE: begin
                acc_next = '0;
                if (cfg_take) begin
                    fword_next = cfg_fword;
                    poff_next  = cfg_poff;
                end
                if (en) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (!en) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    if (cfg_take) begin
                        fword_next = cfg_fword;
                        poff_next  = cfg_poff;
                    end
                end else begin
                    acc_next   = acc_sum;
                    carry_next = carry;
                    // a config landing on a wrap edge waits for the following wrap
                    if (cfg_take) begin
                        sh_fword_next = cfg_fword;
                        sh_poff_next  = cfg_poff;
                        state_next    = PEND;
                    end
                end
            end
            PEND: begin
                if (!en) begin
                    state_next = IDLE;
                    acc_next   = '0;
                    fword_next = sh_fword_reg;
                    poff_next  = sh_poff_reg;
                end else begin
                    acc_next   = acc_sum;
                    carry_next = carry;
                    if (carry) begin
                        fword_next = sh_fword_reg;
                        poff_next  = sh_poff_reg;
                        state_next = RUN;
                    end
                end
            end
            default: begin
                state_next = IDLE;
                acc_next   = '0;
            end
        endcase

        addr_valid_next = (state_reg != IDLE);
        wrap_next       = carry_reg & addr_valid_next;
        addr_next       = ADDR_WIDTH'(phase_sum >> (PHASE_WIDTH - ADDR_WIDTH));
    end

    always_ff @(posedge clk_tb or posedge tb_rst) begin
        if (tb_rst) begin
            state_reg    <= IDLE;
            acc_reg      <= '0;
            fword_reg    <= '0;
            poff_reg     <= '0;
            sh_fword_reg <= '0;
            sh_poff_reg  <= '0;
            live_reg     <= 1'b0;
            carry_reg    <= 1'b0;
            addr_o       <= '0;
            addr_valid   <= 1'b0;
            wrap_o       <= 1'b0;
        end else begin
            state_reg    <= state_next;
            acc_reg      <= acc_next;
            fword_reg    <= fword_next;
            poff_reg     <= poff_next;
            sh_fword_reg <= sh_fword_next;
            sh_poff_reg  <= sh_poff_next;
            live_reg     <= 1'b1;
            carry_reg    <= carry_next;
            addr_o       <= addr_next;
            addr_valid   <= addr_valid_next;
            wrap_o       <= wrap_next;
        end
    end

endmodule
